axi4_lat_inject: RTL



---
 rtl/axi4_lat_inject_pkg.sv | 47 ++++
 rtl/axi4_lat_fifo.sv | 74 +++++++
 rtl/axi4_lat_inject.sv | 82 ++++++++
 3 files changed

// File: rtl/axi4_lat_inject_pkg.sv
// rtl/axi4_lat_inject_pkg.sv - shared types, widths and helpers for the AXI4 latency injector
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi4_lat_inject_pkg;
  localparam int TS_WIDTH   = 16;
  localparam int JIT_WIDTH  = 4;
  localparam int PKG_ID_W   = `AXI_ID_WIDTH;
  localparam int PKG_DATA_W = `AXI_DATA_WIDTH;

  typedef logic [TS_WIDTH-1:0]  ts_t;
  typedef logic [JIT_WIDTH-1:0] jit_t;

  typedef struct packed {
    logic [PKG_ID_W-1:0]   id;
    logic [PKG_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    ts_t                   ts;
    jit_t                  jit;
  } r_entry_t;

  typedef struct packed {
    logic [PKG_ID_W-1:0] id;
    logic [1:0]          resp;
    ts_t                 ts;
    jit_t                jit;
  } b_entry_t;

  // x^4 + x^3 + 1, shift left with feedback into bit 0
  function automatic jit_t lfsr4_next(input jit_t s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // Unsigned modular subtraction keeps the compare correct across counter wrap
  function automatic logic lat_eligible(input ts_t now, input ts_t ts, input jit_t jit, input int lat);
    ts_t               elapsed;
    logic [TS_WIDTH:0] thr;
    elapsed = now - ts;
    thr     = (TS_WIDTH+1)'(lat) + (TS_WIDTH+1)'(jit);
    return {1'b0, elapsed} >= thr;
  endfunction
endpackage

// File: rtl/axi4_lat_fifo.sv
// rtl/axi4_lat_fifo.sv - timestamped delay FIFO releasing its head LAT(+jit) cycles after push
// Optional per-entry jitter when AXI4_LAT_INJECT_JITTER_EN is defined.
module axi4_lat_fifo
  import axi4_lat_inject_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int LAT   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ts_t          cnt_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  ts_t          ts_q  [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         full, empty, push, pop;
  jit_t         head_jit;

  assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty       = (wr_q == rd_q);
  assign in_ready_o  = !full;
  assign push        = in_valid_i && !full;
  assign out_data_o  = mem_q[rd_q[AW-1:0]];
  assign out_valid_o = !empty && lat_eligible(cnt_i, ts_q[rd_q[AW-1:0]], head_jit, LAT);
  assign pop         = out_valid_o && out_ready_i;
  assign wr_d        = wr_q + (AW+1)'(push);
  assign rd_d        = rd_q + (AW+1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        ts_q[i]  <= '0;
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= in_data_i;
        ts_q[wr_q[AW-1:0]]  <= cnt_i;
      end
    end
  end

`ifdef AXI4_LAT_INJECT_JITTER_EN
  jit_t lfsr_q;
  jit_t jit_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 4'b1001;
      for (int i = 0; i < DEPTH; i++) jit_q[i] <= '0;
    end else if (push) begin
      lfsr_q              <= lfsr4_next(lfsr_q);
      jit_q[wr_q[AW-1:0]] <= lfsr_q;
    end
  end

  assign head_jit = jit_q[rd_q[AW-1:0]];
`else
  assign head_jit = '0;
`endif
endmodule

// File: rtl/axi4_lat_inject.sv
// rtl/axi4_lat_inject.sv - delays AXI4 R beats and B responses toward the bridge by a programmable latency
// Jitter option: AXI4_LAT_INJECT_JITTER_EN.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module axi4_lat_inject
  import axi4_lat_inject_pkg::*;
#(
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int R_LAT      = 20,
  parameter int B_LAT      = 10,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);
  localparam int RW = ID_WIDTH + DATA_WIDTH + 3;
  localparam int BW = ID_WIDTH + 2;

  ts_t cnt_q, cnt_d;
  assign cnt_d = cnt_q + ts_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  logic [RW-1:0] r_out;
  logic [BW-1:0] b_out;

  axi4_lat_fifo #(.W(RW), .DEPTH(DEPTH), .LAT(R_LAT)) u_r_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_i       (cnt_q),
    .in_data_i   ({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
    .in_valid_i  (m_axi_rvalid),
    .in_ready_o  (m_axi_rready),
    .out_data_o  (r_out),
    .out_valid_o (s_axi_rvalid),
    .out_ready_i (s_axi_rready)
  );

  axi4_lat_fifo #(.W(BW), .DEPTH(DEPTH), .LAT(B_LAT)) u_b_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_i       (cnt_q),
    .in_data_i   ({m_axi_bid, m_axi_bresp}),
    .in_valid_i  (m_axi_bvalid),
    .in_ready_o  (m_axi_bready),
    .out_data_o  (b_out),
    .out_valid_o (s_axi_bvalid),
    .out_ready_i (s_axi_bready)
  );

  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;
  assign {s_axi_bid, s_axi_bresp}                           = b_out;
endmodule
